// File: rtl/mem_pkg.sv
// Shared definitions for the cache-to-memory block port, used by the cache and the responder.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAT,
        RBURST,
        WBURST
    } mem_state_t;

    localparam int BLOCK_BYTES       = 128;
    localparam int BLOCK_OFFSET_BITS = 7;

endpackage

// File: rtl/main_mem_responder_if.sv
// Cache-to-memory block port. mem_err exists only when MEM_ERR_CHECK_EN is defined.
interface main_mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_ren;
    logic                  mem_wen;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  mem_dvalid;
    logic                  mem_wack;
    logic                  mem_rdy;
`ifdef MEM_ERR_CHECK_EN
    logic                  mem_err;
`endif

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_din,
        input  mem_dout, mem_dvalid, mem_wack, mem_rdy
`ifdef MEM_ERR_CHECK_EN
      , input  mem_err
`endif
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_din,
        output mem_dout, mem_dvalid, mem_wack, mem_rdy
`ifdef MEM_ERR_CHECK_EN
      , output mem_err
`endif
    );

endinterface

// File: rtl/mem_word_array.sv
// Single-port word RAM with a registered read, shaped to infer block RAM.
module mem_word_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 4096,
    parameter int IDX_W      = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // No reset on storage or read register so the tools can map both into a block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/main_mem_responder.sv
// Main-memory responder: accepts one block request, waits MEM_LATENCY, then streams or sinks a block.
// Define MEM_ERR_CHECK_EN to reject misaligned or out-of-range requests with a mem_err pulse.
module main_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_WORDS = 32,
    parameter int MEM_WORDS   = 4096,
    parameter int MEM_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    main_mem_responder_if.slave  bus
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam int LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_LOAD  = (MEM_LATENCY > 0) ? LAT_W'(MEM_LATENCY - 1) : '0;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

    mem_state_t            state_q, state_d;
    logic [IDX_W-1:0]      base_q, base_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  isWrite_q, isWrite_d;
    logic                  rdy_q, rdy_d;
    logic                  dvalid_q, dvalid_d;
    logic                  err_d;
    logic                  reqBad;
    logic [IDX_W-1:0]      reqIndex;
    logic                  ramWe;
    logic [IDX_W-1:0]      ramAddr;
    logic [DATA_WIDTH-1:0] ramRdata;

    // Block offset bits are dropped; upper bits beyond the array wrap away.
    assign reqIndex = {bus.mem_addr[IDX_W+1:BEAT_W+2], BEAT_W'(0)};

`ifdef MEM_ERR_CHECK_EN
    logic err_q;
    assign reqBad = (bus.mem_addr[BLOCK_OFFSET_BITS-1:0] != '0) ||
                    (bus.mem_addr >= ADDR_WIDTH'(MEM_WORDS * 4));
    assign bus.mem_err = err_q;
`else
    logic unusedAddrBits;
    assign reqBad         = 1'b0;
    assign unusedAddrBits = ^{bus.mem_addr[ADDR_WIDTH-1:IDX_W+2], bus.mem_addr[BEAT_W+1:0], err_d};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            isWrite_q <= 1'b0;
            rdy_q     <= 1'b0;
            dvalid_q  <= 1'b0;
`ifdef MEM_ERR_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            isWrite_q <= isWrite_d;
            rdy_q     <= rdy_d;
            dvalid_q  <= dvalid_d;
`ifdef MEM_ERR_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        isWrite_d = isWrite_q;
        err_d     = 1'b0;
        ramWe     = 1'b0;
        ramAddr   = base_q + IDX_W'(beat_q);

        case (state_q)
            IDLE: begin
                if (rdy_q && (bus.mem_ren || bus.mem_wen)) begin
                    if (reqBad) begin
                        err_d = 1'b1;
                    end else begin
                        // A simultaneous read is dropped; the cache re-requests it later.
                        isWrite_d = bus.mem_wen;
                        base_d    = reqIndex;
                        beat_d    = '0;
                        lat_d     = LAT_LOAD;
                        if (MEM_LATENCY == 0) begin
                            state_d = bus.mem_wen ? WBURST : RBURST;
                        end else begin
                            state_d = LAT;
                        end
                    end
                end
            end
            LAT: begin
                if (lat_q == '0) begin
                    state_d = isWrite_q ? WBURST : RBURST;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            RBURST, WBURST: begin
                ramWe = (state_q == WBURST);
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The last read beat leaves the output register one cycle after RBURST ends.
        rdy_d    = (state_d == IDLE) && (state_q != RBURST);
        dvalid_d = (state_q == RBURST);
    end

    mem_word_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk    (clk),
        .we_i   (ramWe),
        .addr_i (ramAddr),
        .wdata_i(bus.mem_din),
        .rdata_o(ramRdata)
    );

    assign bus.mem_dout   = dvalid_q ? ramRdata : '0;
    assign bus.mem_dvalid = dvalid_q;
    assign bus.mem_wack   = (state_q == WBURST);
    assign bus.mem_rdy    = rdy_q;

endmodule
